kitt_sequencer: RTL

Scanning-light sequencer that drives the LED bar of the KITT scanner. It consumes the debounced, already-synchronous enable from the input debouncer stage. While enabled it sweeps a single lit head back and forth across the LEDs at a selectable step rate, optionally trailing a PWM-faded tail. It sits directly between the debouncer and the output pins.

---
 rtl/kitt_pkg.sv | 17 +
 rtl/kitt_prescaler.sv | 41 ++++
 rtl/kitt_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/kitt_pkg.sv
// Shared types and constants for the KITT scanner sequencer.
package kitt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRunUp,
        StRunDown
    } kitt_state_e;

    localparam int unsigned DefStepCycles = 1000000;
    localparam int unsigned DefPwmBits    = 4;

    // Tail duty cycle expressed as a right-shift of the PWM period: prev1 1/2, prev2 1/4.
    localparam int unsigned Prev1Shift = 1;
    localparam int unsigned Prev2Shift = 2;

endpackage

// File: rtl/kitt_prescaler.sv
// Reloading step-rate down-counter; step_tick is high in the cycle the count sits at zero.
module kitt_prescaler
    import kitt_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = DefStepCycles,
    parameter int unsigned CNT_W       = $clog2(STEP_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       run,
    input  logic [1:0] speed,
    output logic       step_tick
);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [CNT_W-1:0] reload;
    logic [31:0]      period;

    // speed only matters at reload, so a mid-step change waits for the next step.
    always_comb begin
        period    = STEP_CYCLES >> speed;
        reload    = CNT_W'(period - 32'd1);
        step_tick = run && (cnt_q == '0);
        cnt_d     = cnt_q;
        if (load || step_tick) begin
            cnt_d = reload;
        end else if (run) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/kitt_sequencer.sv
// KITT scanning-light sequencer. Define KITT_TAIL_EN to add the two-position PWM-faded tail.
module kitt_sequencer
    import kitt_pkg::*;
#(
    parameter int unsigned N_LEDS      = 8,
    parameter int unsigned STEP_CYCLES = DefStepCycles,
    parameter int unsigned PWM_BITS    = DefPwmBits
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    input  logic [1:0]                speed,
    output logic [N_LEDS-1:0]         led,
    output logic [$clog2(N_LEDS)-1:0] pos,
    output logic                      dir
);

    localparam int unsigned POS_W = $clog2(N_LEDS);
    localparam logic [POS_W-1:0] LastPos = POS_W'(N_LEDS - 1);

    kitt_state_e      state_d, state_q;
    logic [POS_W-1:0] head_d, head_q;
    logic             load, run, step_tick;
    logic [N_LEDS-1:0] head_mask, tail_mask;
    logic [N_LEDS-1:0] led_d, led_q;
    logic [POS_W-1:0]  pos_d, pos_q;
    logic              dir_d, dir_q;

    assign load = ena && (state_q == StIdle);
    assign run  = ena && (state_q != StIdle);

    kitt_prescaler #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .run       (run),
        .speed     (speed),
        .step_tick (step_tick)
    );

    // Dropping ena wins over a coincident step_tick.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        unique case (state_q)
            StIdle: begin
                head_d = '0;
                if (ena) state_d = StRunUp;
            end
            StRunUp: begin
                if (!ena) begin
                    state_d = StIdle;
                    head_d  = '0;
                end else if (step_tick) begin
                    if (head_q == LastPos) begin
                        head_d  = LastPos - POS_W'(1);
                        state_d = StRunDown;
                    end else begin
                        head_d = head_q + POS_W'(1);
                    end
                end
            end
            StRunDown: begin
                if (!ena) begin
                    state_d = StIdle;
                    head_d  = '0;
                end else if (step_tick) begin
                    if (head_q == '0) begin
                        head_d  = POS_W'(1);
                        state_d = StRunUp;
                    end else begin
                        head_d = head_q - POS_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                head_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            head_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
        end
    end

    assign head_mask = N_LEDS'(1) << head_q;

`ifdef KITT_TAIL_EN
    localparam logic [PWM_BITS-1:0] Prev1Lim = PWM_BITS'(1) << (PWM_BITS - Prev1Shift);
    localparam logic [PWM_BITS-1:0] Prev2Lim = PWM_BITS'(1) << (PWM_BITS - Prev2Shift);

    logic [POS_W-1:0]    prev1_d, prev1_q, prev2_d, prev2_q;
    logic                prev1_vld_d, prev1_vld_q, prev2_vld_d, prev2_vld_q;
    logic [PWM_BITS-1:0] pwm_d, pwm_q;

    // Overlap with the head at an end bounce is harmless: the OR keeps the head fully lit.
    always_comb begin
        pwm_d       = pwm_q + PWM_BITS'(1);
        prev1_d     = prev1_q;
        prev2_d     = prev2_q;
        prev1_vld_d = prev1_vld_q;
        prev2_vld_d = prev2_vld_q;
        if (load) begin
            prev1_vld_d = 1'b0;
            prev2_vld_d = 1'b0;
        end else if (run && step_tick) begin
            prev2_d     = prev1_q;
            prev2_vld_d = prev1_vld_q;
            prev1_d     = head_q;
            prev1_vld_d = 1'b1;
        end
        tail_mask = '0;
        if (prev1_vld_q && (pwm_q < Prev1Lim)) tail_mask = tail_mask | (N_LEDS'(1) << prev1_q);
        if (prev2_vld_q && (pwm_q < Prev2Lim)) tail_mask = tail_mask | (N_LEDS'(1) << prev2_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q       <= '0;
            prev1_q     <= '0;
            prev2_q     <= '0;
            prev1_vld_q <= 1'b0;
            prev2_vld_q <= 1'b0;
        end else begin
            pwm_q       <= pwm_d;
            prev1_q     <= prev1_d;
            prev2_q     <= prev2_d;
            prev1_vld_q <= prev1_vld_d;
            prev2_vld_q <= prev2_vld_d;
        end
    end
`else
    assign tail_mask = '0;
`endif

    always_comb begin
        led_d = '0;
        pos_d = '0;
        dir_d = 1'b1;
        if (state_q != StIdle) begin
            led_d = head_mask | tail_mask;
            pos_d = head_q;
            dir_d = (state_q == StRunUp);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= '0;
            pos_q <= '0;
            dir_q <= 1'b1;
        end else begin
            led_q <= led_d;
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign led = led_q;
    assign pos = pos_q;
    assign dir = dir_q;

endmodule
